// File: rtl/axis_capture_ram_if.sv
// AXI4-Stream beat bundle (data/valid/ready) between a stream source and the capture buffer.
interface axis_capture_ram_if #(
  parameter int DATA_W = 512
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_capture_ram.sv
// AXIS sink that captures a start..stop address window of beats into RAM after arm + trigger.
// Optional trigger timestamp counter enabled by defining AXIS_CAP_TIMESTAMP_EN.
module axis_capture_ram #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10
) (
  input  logic              pl_clk,
  input  logic              pl_rst,
  axis_capture_ram_if.slave s_axis,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] stop_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   beat_cnt,
  output logic [31:0]       trig_ts
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
  logic [ADDR_W-1:0] stop_q, stop_next;
  logic [ADDR_W:0]   cnt, cnt_next;
  logic              ready_q;
  logic              wr_en;
  logic              trig_take;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // abort outranks arm, arm outranks trig; arm while already ARMED is a no-op that still masks trig
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    stop_next   = stop_q;
    cnt_next    = cnt;
    wr_en       = 1'b0;
    trig_take   = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else if (arm && state != ST_ARMED) begin
      state_next  = ST_ARMED;
      wr_ptr_next = start_addr;
      stop_next   = stop_addr;
      cnt_next    = '0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (trig && !arm) begin
            trig_take  = 1'b1;
            state_next = ST_CAPTURE;
            wr_en      = s_axis.tvalid && ready_q;
          end
        end
        ST_CAPTURE: wr_en = s_axis.tvalid && ready_q;
        default: ;
      endcase
      if (wr_en) begin
        wr_ptr_next = wr_ptr + 1'b1;
        cnt_next    = cnt + 1'b1;
        if (wr_ptr == stop_q) state_next = ST_DONE;
      end
    end
  end

  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      stop_q  <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      wr_ptr  <= wr_ptr_next;
      stop_q  <= stop_next;
      cnt     <= cnt_next;
      ready_q <= 1'b1;
    end
  end

  // RAM is deliberately left out of reset so a reset mid-capture keeps earlier data
  always_ff @(posedge pl_clk) begin
    if (wr_en) mem[wr_ptr] <= s_axis.tdata;
  end

  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

`ifdef AXIS_CAP_TIMESTAMP_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      cycle_cnt <= '0;
      trig_ts   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (trig_take) trig_ts <= cycle_cnt;
    end
  end
`else
  assign trig_ts = 32'd0;
`endif

  assign s_axis.tready = ready_q;
  assign busy          = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign done          = (state == ST_DONE);
  assign beat_cnt      = cnt;

endmodule

// File: tb/tb_axis_capture_ram.sv
// Self-checking bench for axis_capture_ram: directed capture scenarios with random beat data.
module tb_axis_capture_ram;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              pl_clk = 1'b0;
  logic              pl_rst;
  logic              arm, abort, trig, rd_en;
  logic [ADDR_W-1:0] start_addr, stop_addr, rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, busy, done;
  logic [ADDR_W:0]   beat_cnt;
  logic [31:0]       trig_ts;

  axis_capture_ram_if #(.DATA_W(DATA_W)) s_axis ();

  axis_capture_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .pl_clk     (pl_clk),
    .pl_rst     (pl_rst),
    .s_axis     (s_axis),
    .arm        (arm),
    .abort      (abort),
    .trig       (trig),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .beat_cnt   (beat_cnt),
    .trig_ts    (trig_ts)
  );

  always #5 pl_clk = ~pl_clk;

  // expected RAM image: what software should read back from each written address
  logic [DATA_W-1:0] model_mem [DEPTH];
  int total = 0;
  int bad   = 0;
  int unsigned cyc;

  // cycles elapsed since reset release, the reference time base for trigger stamps
  always @(posedge pl_clk) begin
    if (pl_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pl_clk);
  endtask

  task automatic apply_stimulus_idle();
    arm = 1'b0; abort = 1'b0; trig = 1'b0; rd_en = 1'b0;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic arm_window(input logic [ADDR_W-1:0] st, input logic [ADDR_W-1:0] sp);
    start_addr = st; stop_addr = sp; arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic read_check(input int addr, input string tag);
    rd_addr = ADDR_W'(addr); rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_output({tag, "_valid"}, rd_valid, 1);
    check_output(tag, rd_data, model_mem[addr]);
  endtask

  // window capture: trigger beat plus random-gapped beats until N are accepted
  task automatic apply_stimulus_capture(input logic [ADDR_W-1:0] st, input logic [ADDR_W-1:0] sp,
                                        input int gap_pct, input string tag);
    logic [ADDR_W-1:0] diff;
    logic [DATA_W-1:0] d;
    int n, sent, guard;
    diff = sp - st;
    n = int'(diff) + 1;
    arm_window(st, sp);
    check_output({tag, "_armed_busy"}, busy, 1);
    check_output({tag, "_armed_cnt"}, beat_cnt, 0);
    d = rand_beat();
    s_axis.tdata = d; s_axis.tvalid = 1'b1; trig = 1'b1;
    step();
    trig = 1'b0;
    model_mem[int'(st)] = d;
    sent = 1;
    guard = 0;
    while (sent < n && guard < 2000) begin
      check_output({tag, "_not_done_yet"}, done, 0);
      if ($urandom_range(99) < gap_pct) begin
        s_axis.tvalid = 1'b0;
      end else begin
        d = rand_beat();
        s_axis.tdata = d; s_axis.tvalid = 1'b1;
        model_mem[(int'(st) + sent) % DEPTH] = d;
        sent++;
      end
      step();
      guard++;
    end
    check_output({tag, "_timeout"}, guard < 2000, 1);
    check_output({tag, "_done"}, done, 1);
    check_output({tag, "_busy_off"}, busy, 0);
    check_output({tag, "_cnt"}, beat_cnt, (ADDR_W+1)'(n));
    for (int i = 0; i < 3; i++) begin
      s_axis.tdata = rand_beat(); s_axis.tvalid = 1'b1;
      step();
    end
    s_axis.tvalid = 1'b0;
    check_output({tag, "_done_hold"}, done, 1);
    check_output({tag, "_cnt_hold"}, beat_cnt, (ADDR_W+1)'(n));
    for (int i = 0; i < n; i++) read_check((int'(st) + i) % DEPTH, {tag, "_ram"});
  endtask

  initial begin
    logic [DATA_W-1:0] d, old_val, held;
    logic [31:0] ts_exp;
    int guard;

    pl_rst = 1'b1;
    apply_stimulus_idle();
    start_addr = '0; stop_addr = '0; rd_addr = '0; s_axis.tdata = '0;
    step(); step();
    check_output("rst_tready", s_axis.tready, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_cnt", beat_cnt, 0);
    check_output("rst_rd_valid", rd_valid, 0);
    check_output("rst_rd_data", rd_data, 0);
    check_output("rst_trig_ts", trig_ts, 0);
    pl_rst = 1'b0;
    step();
    check_output("tready_after_rst", s_axis.tready, 1);

    // idle beats are discarded
    for (int i = 0; i < 50; i++) begin
      s_axis.tdata = rand_beat(); s_axis.tvalid = 1'b1;
      step();
    end
    s_axis.tvalid = 1'b0;
    check_output("idle_cnt", beat_cnt, 0);
    check_output("idle_busy", busy, 0);
    check_output("idle_done", done, 0);

    apply_stimulus_capture(10'h010, 10'h013, 0, "basic");
    apply_stimulus_capture(10'h010, 10'h013, 50, "gaps");
    apply_stimulus_capture(10'h000, 10'h007, 20, "preload");
    apply_stimulus_capture(10'h3FE, 10'h001, 30, "wrap");
    read_check(2, "wrap_untouched");

    // read hold: rd_valid drops, rd_data keeps last value
    held = model_mem[2];
    step();
    check_output("rd_valid_drop", rd_valid, 0);
    check_output("rd_data_hold", rd_data, held);

    // single-beat window with a same-address read in the write cycle
    old_val = model_mem[5];
    arm_window(10'h005, 10'h005);
    d = rand_beat();
    s_axis.tdata = d; s_axis.tvalid = 1'b1; trig = 1'b1;
    rd_addr = 10'h005; rd_en = 1'b1;
    step();
    trig = 1'b0; rd_en = 1'b0; s_axis.tvalid = 1'b0;
    check_output("single_read_first", rd_data, old_val);
    check_output("single_done", done, 1);
    check_output("single_cnt", beat_cnt, 1);
    model_mem[5] = d;
    read_check(5, "single_ram");
    read_check(6, "single_neighbor");

    // abort after 2 of 4 beats keeps the partial count
    arm_window(10'h020, 10'h023);
    d = rand_beat();
    s_axis.tdata = d; s_axis.tvalid = 1'b1; trig = 1'b1;
    step();
    trig = 1'b0;
    model_mem[32] = d;
    d = rand_beat();
    s_axis.tdata = d;
    step();
    model_mem[33] = d;
    s_axis.tvalid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    check_output("abort_cnt", beat_cnt, 2);
    read_check(32, "abort_ram0");
    read_check(33, "abort_ram1");

    // arm and trig together: trig is dropped, stays ARMED
    start_addr = 10'h030; stop_addr = 10'h033;
    arm = 1'b1; trig = 1'b1; s_axis.tdata = rand_beat(); s_axis.tvalid = 1'b1;
    step();
    arm = 1'b0; trig = 1'b0;
    check_output("armtrig_busy", busy, 1);
    check_output("armtrig_cnt", beat_cnt, 0);
    s_axis.tdata = rand_beat();
    step();
    s_axis.tvalid = 1'b0;
    check_output("armed_no_write", beat_cnt, 0);
    check_output("armed_not_done", done, 0);

    // reset in the middle of a capture, then trigger at cycle 1000
    trig = 1'b1; s_axis.tdata = rand_beat(); s_axis.tvalid = 1'b1;
    step();
    trig = 1'b0; s_axis.tvalid = 1'b0;
    pl_rst = 1'b1;
    step();
    pl_rst = 1'b0;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_cnt", beat_cnt, 0);
    check_output("midrst_ts", trig_ts, 0);
    read_check(16, "ram_kept_after_rst");
    arm_window(10'h100, 10'h101);
    guard = 0;
    while (cyc < 1000 && guard < 2000) begin
      step();
      guard++;
    end
    check_output("ts_wait_timeout", cyc == 1000, 1);
`ifdef AXIS_CAP_TIMESTAMP_EN
    ts_exp = 32'd1000;
`else
    ts_exp = 32'd0;
`endif
    trig = 1'b1; s_axis.tdata = rand_beat(); s_axis.tvalid = 1'b1;
    step();
    trig = 1'b0; s_axis.tvalid = 1'b0;
    step(); step();
    check_output("trig_ts", trig_ts, ts_exp);
    check_output("ts_busy", busy, 1);
    check_output("ts_cnt", beat_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
